// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory responder's MMIO window:
// register offsets, STATUS bit layout and the masked-merge helper.
package mmio_pkg;

  localparam int MMIO_WINDOW_BYTES = 256;
  localparam int MMIO_OFS_W        = $clog2(MMIO_WINDOW_BYTES);

  localparam logic [MMIO_OFS_W-1:0] MMIO_CYCLE_LO   = 8'h00;
  localparam logic [MMIO_OFS_W-1:0] MMIO_CYCLE_HI   = 8'h04;
  localparam logic [MMIO_OFS_W-1:0] MMIO_SCRATCH    = 8'h08;
  localparam logic [MMIO_OFS_W-1:0] MMIO_CONSOLE_TX = 8'h0C;
  localparam logic [MMIO_OFS_W-1:0] MMIO_STATUS     = 8'h10;
  localparam logic [MMIO_OFS_W-1:0] MMIO_TOHOST     = 8'h14;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 4;
  localparam int STATUS_COUNT_W      = 9;

  // Per-bit store merge shared by RAM words and SCRATCH.
  function automatic logic [31:0] masked_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (old_word & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO without fall-through; pushes while full are dropped
// unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  level;
  logic              do_push;
  logic              do_pop;

  assign empty = (level == '0);
  assign full  = (level == CNT_W'(DEPTH));
  assign count = level;

  // A pop on an empty FIFO is ignored, so push+pop when empty is push only.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so the output is clean out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// CPU data-memory responder: masked-write word RAM plus an MMIO window with
// cycle counter, scratch, console TX FIFO and a sticky halt/exit register.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  input  logic [31:0] i_write_mask,
  input  logic        i_write_enable,
  input  logic        i_read_enable,
  output logic [31:0] o_read_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_halt,
  output logic [31:0] o_exit_code
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  is_mmio;
  logic [IDX_W-1:0]      idx;
  logic [MMIO_OFS_W-1:0] offset;
  logic [31:0]           ram [DEPTH_WORDS];
  logic [31:0]           ram_rdata;
  logic [31:0]           mmio_rdata;
  logic [31:0]           status;

  logic [63:0]           cycle;
  logic [31:0]           cycle_hi;
  logic [31:0]           scratch;
  logic                  overflow;
  logic                  halt;
  logic [31:0]           exit_code;

  logic                  mmio_wr;
  logic                  lo_read;
  logic                  scratch_wr;
  logic                  tohost_wr;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused;

  assign unused = &{1'b0, i_addr[1:0]};

  assign is_mmio = (i_addr[31:MMIO_OFS_W] == MMIO_BASE[31:MMIO_OFS_W]);
  assign idx     = i_addr[IDX_W+1:2];
  assign offset  = {i_addr[MMIO_OFS_W-1:2], 2'b00};

  assign mmio_wr    = i_write_enable && is_mmio;
  assign lo_read    = i_read_enable && is_mmio && (offset == MMIO_CYCLE_LO);
  assign scratch_wr = mmio_wr && (offset == MMIO_SCRATCH);
  assign tohost_wr  = mmio_wr && (offset == MMIO_TOHOST);
  assign tx_push    = mmio_wr && (offset == MMIO_CONSOLE_TX) && (|i_write_mask[7:0]);
  assign tx_pop     = o_tx_valid && i_tx_ready;

  // RAM: asynchronous read, masked read-modify-write on the clock edge.
  assign ram_rdata = ram[idx];

  always_ff @(posedge i_clk) begin
    if (i_write_enable && !is_mmio)
      ram[idx] <= masked_merge(ram[idx], i_write_data, i_write_mask);
  end

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (i_write_data[7:0]),
    .rdata (o_tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign o_tx_valid = !fifo_empty;

  always_comb begin
    status = '0;
    status[STATUS_EMPTY_BIT]    = fifo_empty;
    status[STATUS_FULL_BIT]     = fifo_full;
    status[STATUS_OVERFLOW_BIT] = overflow;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      MMIO_CYCLE_LO: mmio_rdata = cycle[31:0];
      MMIO_CYCLE_HI: mmio_rdata = cycle_hi;
      MMIO_SCRATCH:  mmio_rdata = scratch;
      MMIO_STATUS:   mmio_rdata = status;
      MMIO_TOHOST:   mmio_rdata = exit_code;
      default:       mmio_rdata = '0;
    endcase
  end

  assign o_read_data = is_mmio ? mmio_rdata : ram_rdata;

  // Reading CYCLE_LO snapshots the upper half so a later CYCLE_HI read
  // pairs with it even if the low word has wrapped in between.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle     <= '0;
      cycle_hi  <= '0;
      scratch   <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (lo_read)
        cycle_hi <= cycle[63:32];
      if (scratch_wr)
        scratch <= masked_merge(scratch, i_write_data, i_write_mask);
      if (tx_push && fifo_full && !tx_pop)
        overflow <= 1'b1;
      if (tohost_wr && !halt) begin
        halt      <= 1'b1;
        exit_code <= i_write_data;
      end
    end
  end

  assign o_halt      = halt;
  assign o_exit_code = exit_code;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with read and console scoreboards.
module tb_dmem_mmio_responder;
  import mmio_pkg::*;

  localparam int          DEPTH_WORDS = 2048;
  localparam logic [31:0] BASE        = 32'h8000_0000;
  localparam logic [31:0] A_LO        = BASE + 32'h00;
  localparam logic [31:0] A_HI        = BASE + 32'h04;
  localparam logic [31:0] A_SCR       = BASE + 32'h08;
  localparam logic [31:0] A_TX        = BASE + 32'h0C;
  localparam logic [31:0] A_ST        = BASE + 32'h10;
  localparam logic [31:0] A_TOHOST    = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mask;
  logic        we;
  logic        re;
  logic        tx_ready;
  logic [31:0] read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        halt;
  logic [31:0] exit_code;

  dmem_mmio_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MMIO_BASE   (BASE),
    .FIFO_DEPTH  (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_addr         (addr),
    .i_write_data   (wdata),
    .i_write_mask   (mask),
    .i_write_enable (we),
    .i_read_enable  (re),
    .o_read_data    (read_data),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .o_halt         (halt),
    .o_exit_code    (exit_code)
  );

  always #5 clk = ~clk;

  // Reference count of rising edges since reset release.
  logic [63:0] edges;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= '0;
    else     edges <= edges + 64'd1;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] rdq[$];
  logic [7:0]  txq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    addr = a; wdata = d; mask = m; we = 1'b1;
    @(negedge clk);
    we = 1'b0; mask = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a; re = 1'b1;
    rdq.push_back(exp);
    #1;
    chk(tag, read_data, rdq.pop_front());
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit kept);
    wr(A_TX, {24'h0, b}, 32'h0000_00ff);
    if (kept) txq.push_back(b);
  endtask

  task automatic drain(input int n, input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_valid"}, tx_valid, 1);
      chk({tag, "_data"}, tx_data, txq.pop_front());
      @(negedge clk);
    end
    #1;
    chk({tag, "_idle"}, tx_valid, 0);
    tx_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; mask = '0; we = 1'b0; re = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_halt", halt, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    rd(A_ST, 32'h1, "rst_status");
    rd(A_SCR, 32'h0, "rst_scratch");
    rd(A_HI, 32'h0, "rst_cycle_hi");
    rd(A_LO, edges[31:0], "cycle_lo_count");

    // RAM masked stores and index wrap
    wr(32'h8, 32'hdeadbeef, 32'hffff_ffff);
    rd(32'h8, 32'hdeadbeef, "ram_full_word");
    wr(32'h8, 32'hb0ba0000, 32'hffff_0000);
    rd(32'h8, 32'hb0babeef, "ram_masked");
    rd(32'h8 + 4 * DEPTH_WORDS, 32'hb0babeef, "ram_alias_read");
    wr(32'h8 + 4 * DEPTH_WORDS, 32'h1234_5678, 32'h0);
    rd(32'h8, 32'hb0babeef, "ram_zero_mask");
    wr(32'h8 + 4 * DEPTH_WORDS, 32'h0000_0011, 32'h0000_00ff);
    rd(32'h8, 32'hb0babe11, "ram_alias_write");
    wr(32'h10, 32'h0bad_f00d, 32'hffff_ffff);
    rd(32'h10, 32'h0bad_f00d, "ram_other_word");
    rd(32'h8, 32'hb0babe11, "ram_no_disturb");

    // Scratch, unmapped offsets and write-only console reads
    wr(A_SCR, 32'h1234_5678, 32'hffff_ffff);
    wr(A_SCR, 32'h0000_aa00, 32'h0000_ff00);
    rd(A_SCR, 32'h1234_aa78, "scratch_merge");
    wr(BASE + 32'h20, 32'hffff_ffff, 32'hffff_ffff);
    rd(BASE + 32'h20, 32'h0, "unmapped_read");
    rd(A_TX, 32'h0, "console_read");
    rd(A_ST, 32'h1, "status_no_push");

    // Cycle coherency across a low-word wrap
    force dut.cycle = 64'h0000_0001_ffff_fffe;
    #1;
    release dut.cycle;
    rd(A_LO, 32'hffff_fffe, "coh_lo");
    @(negedge clk);
    rd(A_HI, 32'h1, "coh_hi_shadow");
    rd(A_LO, 32'h1, "coh_lo_after_wrap");
    rd(A_HI, 32'h2, "coh_hi_relatch");

    // Console with backpressure
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    rd(A_ST, 32'h20, "status_count2");
    drain(2, "bp");
    rd(A_ST, 32'h1, "status_drained");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i), 1'b1);
    rd(A_ST, 32'h102, "status_full");
    addr = A_TX; wdata = 32'h0000_005f; mask = 32'h0000_00ff; we = 1'b1; tx_ready = 1'b1;
    txq.push_back(8'h5f);
    #1;
    chk("simul_valid", tx_valid, 1);
    chk("simul_head", tx_data, txq.pop_front());
    @(negedge clk);
    we = 1'b0; mask = '0; tx_ready = 1'b0;
    rd(A_ST, 32'h102, "status_simul");
    drain(16, "simul");

    // Overflow: 17th byte dropped
    for (int i = 0; i < 17; i++) push_byte(8'h60 + 8'(i), (i < 16));
    rd(A_ST, 32'h106, "status_overflow");
    drain(16, "ovf");
    rd(A_ST, 32'h5, "status_ovf_sticky");

    // TOHOST
    wr(A_TOHOST, 32'h1, 32'hffff_ffff);
    #1;
    chk("halt_set", halt, 1);
    chk("exit_code", exit_code, 32'h1);
    rd(A_TOHOST, 32'h1, "tohost_read");
    wr(A_TOHOST, 32'h5, 32'hffff_ffff);
    #1;
    chk("exit_ignored", exit_code, 32'h1);
    chk("halt_kept", halt, 1);

    // Asynchronous reset in the middle of a drain
    @(negedge clk);
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    push_byte(8'h33, 1'b1);
    tx_ready = 1'b1;
    #1;
    chk("mid_head0", tx_data, txq.pop_front());
    @(negedge clk);
    #1;
    chk("mid_head1", tx_data, txq.pop_front());
    #1;
    rst = 1'b1;
    #1;
    chk("arst_halt", halt, 0);
    chk("arst_exit", exit_code, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    addr = A_LO;
    #1;
    chk("arst_cycle", read_data, 32'h0);
    addr = A_ST;
    #1;
    chk("arst_status", read_data, 32'h1);
    txq.delete();
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd(A_LO, edges[31:0], "post_rst_cycle");
    rd(A_ST, 32'h1, "post_rst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
